// File: rtl/sym_vn_lut_array.sv
// Folded symmetric VN lookup table: N concurrent read channels, two pages,
// paged load port. Optional macro SYM_VN_WR_BYPASS_EN: write-first reads.
module sym_vn_lut_array #(
    parameter int QUAN_SIZE = 4,
    parameter int PORT_NUM  = 2
) (
    input  logic                          sys_clk,
    input  logic                          rstn,
    input  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in,
    input  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in,
    input  logic [PORT_NUM-1:0]           in_valid,
    input  logic                          read_addr_offset,
    output logic [PORT_NUM*QUAN_SIZE-1:0] t_c,
    output logic [PORT_NUM-1:0]           transpose_en_out,
    output logic [PORT_NUM-1:0]           out_valid,
    output logic                          read_addr_offset_out,
    input  logic                          load_start,
    input  logic                          load_offset,
    input  logic                          wr_valid,
    input  logic [QUAN_SIZE-1:0]          wr_data,
    output logic                          load_busy,
    output logic                          load_done
);
    localparam int Q  = QUAN_SIZE;
    localparam int N  = PORT_NUM;
    localparam int CW = 2 * Q - 1;
    localparam int AW = 2 * Q;
    localparam int DEPTH_PER_PAGE = 1 << CW;
    localparam logic [CW-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            ld_off, ld_off_n;
    logic            done_n;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;

    logic [Q-1:0]    mem [2*DEPTH_PER_PAGE];

    logic [N-1:0][Q-2:0] y0f;
    logic [N-1:0][Q-1:0] y1f;
    logic [N-1:0]        msb;

    logic [N-1:0][Q-2:0] s0_y0f;
    logic [N-1:0][Q-1:0] s0_y1f;
    logic [N-1:0]        s0_msb;
    logic [N-1:0]        s0_valid;
    logic                s0_off;

    logic [N-1:0][AW-1:0] rd_addr;
    logic [N-1:0][Q-1:0]  rd_data;

    assign wr_addr   = {ld_off, cnt};
    assign load_busy = (state == LOAD);

    // Fold each channel onto the half table using the y0 sign bit
    always_comb begin
        for (int k = 0; k < N; k++) begin
            msb[k] = y0_in[k*Q+Q-1];
            y0f[k] = y0_in[k*Q +: Q-1];
            y1f[k] = msb[k] ? ~y1_in[k*Q +: Q] : y1_in[k*Q +: Q];
        end
    end

    // Stage 0: register folded address parts and qualifiers
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s0_y0f   <= '0;
            s0_y1f   <= '0;
            s0_msb   <= '0;
            s0_valid <= '0;
            s0_off   <= 1'b0;
        end else begin
            s0_y0f   <= y0f;
            s0_y1f   <= y1f;
            s0_msb   <= msb;
            s0_valid <= in_valid;
            s0_off   <= read_addr_offset;
        end
    end

    // Per-channel table read, optionally forwarding the same-cycle write
    always_comb begin
        for (int k = 0; k < N; k++) begin
            rd_addr[k] = {s0_off, s0_y0f[k], s0_y1f[k]};
            rd_data[k] = mem[rd_addr[k]];
`ifdef SYM_VN_WR_BYPASS_EN
            if (wr_en && (rd_addr[k] == wr_addr)) begin
                rd_data[k] = wr_data;
            end
`endif
        end
    end

    // Stage 1: result registers; data holds while the channel is idle
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            t_c                  <= '0;
            transpose_en_out     <= '0;
            out_valid            <= '0;
            read_addr_offset_out <= 1'b0;
        end else begin
            out_valid            <= s0_valid;
            read_addr_offset_out <= s0_off;
            for (int k = 0; k < N; k++) begin
                if (s0_valid[k]) begin
                    t_c[k*Q +: Q]       <= rd_data[k];
                    transpose_en_out[k] <= s0_msb[k];
                end
            end
        end
    end

    // Table storage is not reset so an aborted load keeps written entries
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Load FSM state, counter, latched page and done pulse
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_off    <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ld_off    <= ld_off_n;
            load_done <= done_n;
        end
    end

    // Load FSM next state and write enable
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ld_off_n = ld_off;
        done_n   = 1'b0;
        wr_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_n  = LOAD;
                    cnt_n    = '0;
                    ld_off_n = load_offset;
                end
            end
            LOAD: begin
                if (wr_valid) begin
                    wr_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sym_vn_lut_array.sv
// Scoreboard bench for sym_vn_lut_array (Q=4, N=2) with a table model.
// Honours SYM_VN_WR_BYPASS_EN for the collision expectation.
module tb_sym_vn_lut_array;
    localparam int Q = 4;
    localparam int N = 2;

    logic       sys_clk = 1'b0;
    logic       rstn;
    logic [7:0] y0_in, y1_in;
    logic [1:0] in_valid;
    logic       read_addr_offset;
    logic [7:0] t_c;
    logic [1:0] transpose_en_out, out_valid;
    logic       read_addr_offset_out;
    logic       load_start, load_offset, wr_valid;
    logic [3:0] wr_data;
    logic       load_busy, load_done;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [3:0] model [256];
    logic [3:0] load_buf [128];

    typedef struct {
        logic [3:0] tc;
        logic       te;
        logic       off;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [3:0] last_tc [2];
    logic       last_te [2];

    sym_vn_lut_array #(.QUAN_SIZE(Q), .PORT_NUM(N)) dut (
        .sys_clk              (sys_clk),
        .rstn                 (rstn),
        .y0_in                (y0_in),
        .y1_in                (y1_in),
        .in_valid             (in_valid),
        .read_addr_offset     (read_addr_offset),
        .t_c                  (t_c),
        .transpose_en_out     (transpose_en_out),
        .out_valid            (out_valid),
        .read_addr_offset_out (read_addr_offset_out),
        .load_start           (load_start),
        .load_offset          (load_offset),
        .wr_valid             (wr_valid),
        .wr_data              (wr_data),
        .load_busy            (load_busy),
        .load_done            (load_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Table address from the folding rule, using plain arithmetic
    function automatic logic [7:0] fold_addr(input logic off,
                                             input logic [3:0] y0,
                                             input logic [3:0] y1);
        int oi, y0i, y1i, a;
        oi  = int'(off);
        y0i = int'(y0);
        y1i = int'(y1);
        a = oi * 128 + (y0i % 8) * 16 + ((y0i >= 8) ? (15 - y1i) : y1i);
        return 8'(a);
    endfunction

    task automatic req_drive(input logic [1:0] v, input logic [7:0] y0p,
                             input logic [7:0] y1p, input logic off);
        exp_t e;
        logic [3:0] y0k, y1k;
        y0_in = y0p;
        y1_in = y1p;
        in_valid = v;
        read_addr_offset = off;
        for (int k = 0; k < N; k++) begin
            if (v[k]) begin
                y0k = y0p[k*4 +: 4];
                y1k = y1p[k*4 +: 4];
                e.tc  = model[fold_addr(off, y0k, y1k)];
                e.te  = y0k[3];
                e.off = off;
                e.cyc = cyc;
                if (k == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
    endtask

    task automatic req_idle();
        req_drive(2'b00, 8'h00, 8'h00, 1'b0);
    endtask

    // Monitor: pop and compare on every valid output, check hold otherwise
    always @(negedge sys_clk) begin
        exp_t e;
        logic [3:0] tck;
        bit got;
        if (!rstn) begin
            for (int k = 0; k < N; k++) begin
                last_tc[k] = 4'h0;
                last_te[k] = 1'b0;
            end
        end else begin
            if (load_done) done_cnt++;
            for (int k = 0; k < N; k++) begin
                tck = t_c[k*4 +: 4];
                got = 1'b0;
                if (out_valid[k]) begin
                    if (k == 0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        got = 1'b1;
                    end else if (k == 1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        got = 1'b1;
                    end
                    if (!got) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected ch%0d: valid with empty queue", k);
                    end else begin
                        chk($sformatf("t_c ch%0d", k), 32'(tck), 32'(e.tc));
                        chk($sformatf("te ch%0d", k),
                            32'(transpose_en_out[k]), 32'(e.te));
                        chk($sformatf("off_out ch%0d", k),
                            32'(read_addr_offset_out), 32'(e.off));
                        chk($sformatf("latency ch%0d", k), 32'(cyc - e.cyc), 32'd2);
                    end
                    last_tc[k] = tck;
                    last_te[k] = transpose_en_out[k];
                end else begin
                    chk($sformatf("hold_tc ch%0d", k), 32'(tck), 32'(last_tc[k]));
                    chk($sformatf("hold_te ch%0d", k),
                        32'(transpose_en_out[k]), 32'(last_te[k]));
                end
            end
        end
    end

    // Page load from load_buf; optional gaps, collision read, bg reads, abort
    task automatic do_load(input logic off, input bit gaps, input int coll,
                           input int n_beats, input bit bg);
        int d0;
        exp_t e;
        logic [6:0] jb;
        logic [7:0] y0p, y1p;
        d0 = done_cnt;
        load_start  = 1'b1;
        load_offset = off;
        req_idle();
        tick();
        load_start = 1'b0;
        chk("busy_start", 32'(load_busy), 32'd1);
        for (int a = 0; a < n_beats; a++) begin
            if (gaps && (a % 7 == 3)) begin
                wr_valid    = 1'b0;
                load_start  = 1'b1;
                load_offset = ~off;
                wr_data     = 4'($urandom);
                req_idle();
                tick();
                load_start = 1'b0;
                chk("busy_gap", 32'(load_busy), 32'd1);
                chk("done_gap", 32'(load_done), 32'd0);
            end
            wr_valid = 1'b1;
            wr_data  = load_buf[a];
            if (coll >= 1 && a == coll - 1) begin
                jb  = 7'(coll);
                y0p = {1'b1, jb[6:4], 1'b0, jb[6:4]};
                y1p = {~jb[3:0], jb[3:0]};
                req_drive(2'b11, y0p, y1p, off);
`ifdef SYM_VN_WR_BYPASS_EN
                e = q0.pop_back();
                e.tc = load_buf[coll];
                q0.push_back(e);
                e = q1.pop_back();
                e.tc = load_buf[coll];
                q1.push_back(e);
`endif
            end else if (bg) begin
                req_drive(2'($urandom), 8'($urandom), 8'($urandom), ~off);
            end else begin
                req_idle();
            end
            model[{off, 7'(a)}] = load_buf[a];
            tick();
            if (a < 127) begin
                chk("busy_beat", 32'(load_busy), 32'd1);
                chk("done_beat", 32'(load_done), 32'd0);
            end else begin
                chk("busy_end", 32'(load_busy), 32'd0);
                chk("done_end", 32'(load_done), 32'd1);
            end
        end
        wr_valid = 1'b0;
        req_idle();
        if (n_beats == 128) begin
            tick();
            chk("done_pulse_off", 32'(load_done), 32'd0);
            chk("done_count", 32'(done_cnt - d0), 32'd1);
        end else begin
            #1 rstn = 1'b0;
            #1;
            chk("rst_t_c", 32'(t_c), 32'd0);
            chk("rst_te", 32'(transpose_en_out), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_off_out", 32'(read_addr_offset_out), 32'd0);
            chk("rst_busy", 32'(load_busy), 32'd0);
            chk("rst_done", 32'(load_done), 32'd0);
            q0.delete();
            q1.delete();
            #5 rstn = 1'b1;
            tick();
            chk("busy_after_abort", 32'(load_busy), 32'd0);
        end
    endtask

    // Read every entry of a page on both channels with random fold sign
    task automatic readback(input logic off);
        logic [6:0] a0, a1;
        logic m0, m1;
        logic [3:0] y00, y10, y01, y11;
        for (int a = 0; a < 128; a++) begin
            a0 = 7'(a);
            a1 = 7'(127 - a);
            m0 = 1'($urandom);
            m1 = 1'($urandom);
            y00 = {m0, a0[6:4]};
            y10 = m0 ? ~a0[3:0] : a0[3:0];
            y01 = {m1, a1[6:4]};
            y11 = m1 ? ~a1[3:0] : a1[3:0];
            req_drive(2'b11, {y01, y00}, {y11, y10}, off);
            tick();
        end
        req_idle();
    endtask

    task automatic rand_stream(input int n);
        logic [7:0] y0p, y1p;
        for (int i = 0; i < n; i++) begin
            y0p = 8'($urandom);
            y1p = 8'($urandom);
            if (i % 9 == 0) begin
                y0p[7:4] = y0p[3:0];
                y1p[7:4] = y1p[3:0];
            end
            req_drive(2'($urandom), y0p, y1p, 1'($urandom));
            tick();
        end
        req_idle();
    endtask

    initial begin
        rstn = 1'b1;
        y0_in = '0;
        y1_in = '0;
        in_valid = '0;
        read_addr_offset = 1'b0;
        load_start = 1'b0;
        load_offset = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        #1 rstn = 1'b0;
        #1;
        chk("init_t_c", 32'(t_c), 32'd0);
        chk("init_valid", 32'(out_valid), 32'd0);
        chk("init_te", 32'(transpose_en_out), 32'd0);
        chk("init_busy", 32'(load_busy), 32'd0);
        chk("init_done", 32'(load_done), 32'd0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #3 rstn = 1'b1;
        tick();

        for (int a = 0; a < 128; a++) load_buf[a] = 4'(a);
        do_load(1'b0, 1'b0, -1, 128, 1'b0);

        wr_valid = 1'b1;
        wr_data = 4'hF;
        tick();
        tick();
        wr_valid = 1'b0;
        chk("idle_wr_busy", 32'(load_busy), 32'd0);

        req_drive(2'b01, 8'h0A, 8'h03, 1'b0);
        tick();
        req_idle();
        tick();
        chk("dir_valid", 32'(out_valid[0]), 32'd1);
        chk("dir_t_c", 32'(t_c[3:0]), 32'hC);
        chk("dir_te", 32'(transpose_en_out[0]), 32'd1);

        req_drive(2'b11, 8'h5A, 8'h31, 1'b0);
        tick();
        req_drive(2'b11, 8'hC3, 8'h7E, 1'b0);
        tick();
        req_drive(2'b11, 8'h18, 8'hA5, 1'b0);
        tick();
        req_idle();
        repeat (3) tick();

        readback(1'b0);

        for (int a = 0; a < 128; a++) load_buf[a] = 4'($urandom);
        do_load(1'b1, 1'b1, -1, 128, 1'b1);
        readback(1'b1);

        for (int a = 0; a < 128; a++) load_buf[a] = 4'($urandom);
        load_buf[50] = ~model[{1'b1, 7'd50}];
        do_load(1'b1, 1'b0, 50, 128, 1'b0);
        readback(1'b1);

        rand_stream(300);

        for (int a = 0; a < 128; a++) load_buf[a] = 4'($urandom);
        do_load(1'b0, 1'b0, -1, 10, 1'b1);
        readback(1'b0);
        rand_stream(100);

        repeat (4) tick();
        chk("sb_drain", 32'(q0.size() + q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
